if_fetch_unit: RTL and testbench

//  Instruction-fetch stage that drives the IF/ID pipeline register. Owns the PC, issues

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 tb/tb_if_fetch_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the fetch-queue payload for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with clear; storage is unreset, occupancy is not.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Upstream credit accounting must never let a write hit a full FIFO.
  push_into_full_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(push && full && !clear));

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues credit-limited fetches and presents queued words to IF/ID.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH        = 2,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            flush_o
);

  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCW = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic            credit_ok;
  logic            grant;
  logic            rsp;
  logic            accept;
  logic            pop;

  fq_entry_t       fq_wdata;
  fq_entry_t       fq_head;
  logic [FCW-1:0]  fq_count;
  logic            fq_empty;
  logic            fq_full;

  logic [XLEN-1:0] tag_head;
  logic [CW-1:0]   tag_count;
  logic            tag_empty;
  logic            tag_full;

  // Credits count words in flight plus words queued; a same-cycle pop is not credited.
  assign credit_ok = (32'(outstanding) < 32'(MAX_OUTSTANDING)) &&
                     ((32'(outstanding) + 32'(fq_count)) < 32'(FQ_DEPTH));

  assign imem_req_o  = rst_i && !redirect_i && credit_ok;
  assign imem_addr_o = pc;
  assign grant       = imem_req_o && imem_gnt_i;
  assign rsp         = imem_rvalid_i && (outstanding != '0);
  assign accept      = rsp && !redirect_i && (drop_cnt == '0) && !tag_empty;
  assign pop         = !stall_i && !redirect_i && !fq_empty;
  assign fq_wdata    = '{pc: tag_head, instr: imem_rdata_i};

  assign instr_o = fq_empty ? NOP_INSTR : fq_head.instr;
  assign pc_o    = fq_empty ? '0 : fq_head.pc;
  assign flush_o = redirect_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect_i) begin
        pc       <= redirect_pc_i;
        // A response landing in the redirect cycle is already dropped here.
        drop_cnt <= outstanding - CW'(rsp);
      end else begin
        if (grant) pc <= next_pc(pc);
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
      outstanding <= outstanding + CW'(grant) - CW'(rsp);
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .WIDTH ($bits(fq_entry_t))
  ) u_instr_q (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (accept),
    .pop   (pop),
    .clear (redirect_i),
    .wdata (fq_wdata),
    .rdata (fq_head),
    .count (fq_count),
    .empty (fq_empty),
    .full  (fq_full)
  );

  // In-order PC tags for granted requests, matched to responses as they return.
  fetch_queue #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (XLEN)
  ) u_tag_q (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (grant),
    .pop   (accept),
    .clear (redirect_i),
    .wdata (pc),
    .rdata (tag_head),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

  tag_bound_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(grant && tag_full) && (32'(tag_count) <= 32'(outstanding)));

  queue_credit_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(accept && fq_full));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a 1-cycle (holdable) in-order memory model.
module tb_if_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;

  int          checks = 0;
  int          passed = 0;
  int          nvalid = 0;
  int          base   = 0;
  logic [31:0] exp_pc;
  bit          mem_hold = 1'b0;
  logic [31:0] rsp_q [$];

  always #5 clk_i = ~clk_i;

  if_fetch_unit #(
    .RESET_PC        (32'h0000_0000),
    .FQ_DEPTH        (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_o       (instr),
    .pc_o          (pc),
    .flush_o       (flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock: record a grant before the edge, then present the next in-order response.
  task automatic tick();
    bit          acc;
    logic [31:0] a;
    acc = imem_req && gnt;
    a   = imem_addr;
    @(posedge clk_i);
    #1;
    if (acc) rsp_q.push_back(a);
    if (!mem_hold && rsp_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = rsp_q.pop_front() ^ KEY;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  endtask

  // Drive one cycle of inputs, check outputs against the expected PC stream, advance.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic gn, input int xreq);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    gnt         = gn;
    #1;
    check("flush", 32'(flush), 32'(rd));
    if (xreq >= 0) check("req", 32'(imem_req), 32'(xreq));
    if (instr != NOP_INSTR) begin
      check("pc", pc, exp_pc);
      check("instr", instr, exp_pc ^ KEY);
      if (!st && !rd) begin
        exp_pc = exp_pc + 32'd4;
        nvalid++;
      end
    end else begin
      check("bubble_pc", pc, 32'h0);
    end
    if (rd) exp_pc = rpc;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = '0;
    gnt = 1'b1; rvalid = 1'b0; rdata = '0; exp_pc = 32'h0;
    #2;
    // Reset: outputs quiet, flush still follows redirect.
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_flush", 32'(flush), 32'h1);
    redirect = 1'b0;
    #1;
    check("rst_flush_lo", 32'(flush), 32'h0);
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    check("rel_addr", imem_addr, 32'h0);
    check("rel_req", 32'(imem_req), 32'h1);

    // Stream: credit limit of 2 gives two words then one bubble per three cycles.
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, (i % 3 == 2) ? 0 : 1);
    check("stream_cnt", 32'(nvalid), 32'd5);

    // Stall 3 cycles: head holds at 0x14, queue fills and requests stop.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("stall_cnt", 32'(nvalid), 32'd7);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1, -1);

    // Build two outstanding requests, then redirect as the first stale word returns.
    mem_hold = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b1, -1);
    mem_hold = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 0);
    check("pre_redir_cnt", 32'(nvalid), 32'd10);
    cyc(1'b0, 1'b1, 32'h0000_0100, 1'b1, 0);
    base = nvalid;
    repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b1, -1);
    check("redir_cnt", 32'(nvalid - base), 32'd4);

    // No grants: drain, then bubbles with a steady request at 0x118.
    cyc(1'b0, 1'b0, 32'h0, 1'b0, -1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, -1);
    check("nognt_addr", imem_addr, 32'h0000_0118);
    for (int i = 0; i < 4; i++) begin
      check("nognt_instr", instr, 32'h0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1);
    end
    repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1, -1);

    // Redirect with credit available: no request that cycle; PC wraps past 2^32.
    cyc(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 0);
    base = nvalid;
    repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b1, -1);
    check("wrap_cnt", 32'(nvalid - base), 32'd4);

    // Fill the queue under stall, then reset mid-operation.
    cyc(1'b1, 1'b0, 32'h0, 1'b1, -1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 0);
    rst_i = 1'b0;
    rsp_q.delete();
    rvalid = 1'b0;
    rdata  = '0;
    stall  = 1'b0;
    #1;
    check("rst2_instr", instr, 32'h0);
    check("rst2_pc", pc, 32'h0);
    check("rst2_req", 32'(imem_req), 32'h0);
    tick();
    tick();
    rst_i  = 1'b1;
    exp_pc = 32'h0;
    base   = nvalid;
    #1;
    check("rst2_addr", imem_addr, 32'h0);
    check("rst2_req_rel", 32'(imem_req), 32'h1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, (i % 3 == 2) ? 0 : 1);
    check("restart_cnt", 32'(nvalid - base), 32'd5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
